decode_queue: RTL and testbench



---
 rtl/rv32i_pkg.sv | 61 ++++++
 rtl/decode_core.sv | 134 +++++++++++++
 rtl/decode_queue.sv | 124 ++++++++++++
 tb/tb_decode_queue.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode types: ALU operations, operand selects, the control bundle,
// its NOP default and the base opcode values.
package rv32i_pkg;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_t;

  typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_t;
  typedef enum logic {OP2_RS2, OP2_IMM} op2_sel_t;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;

  typedef struct packed {
    alu_op_t  alu_op;
    op1_sel_t op1_sel;
    op2_sel_t op2_sel;
    imm_sel_t imm_sel;
    logic     reg_write;
    logic     mem_read;
    logic     mem_write;
    logic [2:0] funct3;
    logic     branch;
    logic     jal;
    logic     jalr;
    logic     system;
  } control_t;

  // addi x0,x0,0 with the register write suppressed
  localparam control_t CTRL_NOP = '{
    alu_op: ALU_ADD, op1_sel: OP1_RS1, op2_sel: OP2_IMM, imm_sel: IMM_I,
    reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0, funct3: 3'b000,
    branch: 1'b0, jal: 1'b0, jalr: 1'b0, system: 1'b0
  };

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  function automatic alu_op_t base_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_core.sv
// Combinational RV32I decoder with illegal-encoding detection.
// Define RV32M_EN to decode the M-extension multiply/divide ops as legal.
module decode_core
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  output control_t    ctrl,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        use_rs1,
  output logic        use_rs2,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  control_t   dec;
  logic       dec_rs1;
  logic       dec_rs2;
  logic       bad;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  always_comb begin
    dec     = CTRL_NOP;
    dec_rs1 = 1'b0;
    dec_rs2 = 1'b0;
    bad     = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_rs1 = 1'b1;
        dec_rs2 = 1'b1;
        dec.op2_sel   = OP2_RS2;
        dec.reg_write = 1'b1;
        case (funct7)
          7'b0000000: dec.alu_op = base_alu(funct3, 1'b0);
          7'b0100000: begin
            if (funct3 == 3'b000 || funct3 == 3'b101) dec.alu_op = base_alu(funct3, 1'b1);
            else bad = 1'b1;
          end
`ifdef RV32M_EN
          7'b0000001: begin
            case (funct3)
              3'b000:  dec.alu_op = ALU_MUL;
              3'b001:  dec.alu_op = ALU_MULH;
              3'b010:  dec.alu_op = ALU_MULHSU;
              3'b011:  dec.alu_op = ALU_MULHU;
              3'b100:  dec.alu_op = ALU_DIV;
              3'b101:  dec.alu_op = ALU_DIVU;
              3'b110:  dec.alu_op = ALU_REM;
              default: dec.alu_op = ALU_REMU;
            endcase
          end
`endif
          default: bad = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        dec_rs1 = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = base_alu(funct3, 1'b0);
        if (funct3 == 3'b001 && funct7 != 7'b0000000) bad = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 == 7'b0100000) dec.alu_op = ALU_SRA;
          else if (funct7 != 7'b0000000) bad = 1'b1;
        end
      end
      OPC_LOAD: begin
        dec_rs1 = 1'b1;
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.funct3    = funct3;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) bad = 1'b1;
      end
      OPC_STORE: begin
        dec_rs1 = 1'b1;
        dec_rs2 = 1'b1;
        dec.mem_write = 1'b1;
        dec.imm_sel   = IMM_S;
        dec.funct3    = funct3;
        if (funct3 >= 3'b011) bad = 1'b1;
      end
      OPC_BRANCH: begin
        dec_rs1 = 1'b1;
        dec_rs2 = 1'b1;
        dec.alu_op  = ALU_SUB;
        dec.op2_sel = OP2_RS2;
        dec.imm_sel = IMM_B;
        dec.branch  = 1'b1;
        dec.funct3  = funct3;
        if (funct3 == 3'b010 || funct3 == 3'b011) bad = 1'b1;
      end
      OPC_JAL: begin
        dec.op1_sel   = OP1_PC;
        dec.imm_sel   = IMM_J;
        dec.reg_write = 1'b1;
        dec.jal       = 1'b1;
      end
      OPC_JALR: begin
        dec_rs1 = 1'b1;
        dec.reg_write = 1'b1;
        dec.jalr      = 1'b1;
        if (funct3 != 3'b000) bad = 1'b1;
      end
      OPC_LUI: begin
        dec.op1_sel   = OP1_ZERO;
        dec.imm_sel   = IMM_U;
        dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec.op1_sel   = OP1_PC;
        dec.imm_sel   = IMM_U;
        dec.reg_write = 1'b1;
      end
      OPC_SYSTEM: dec.system = 1'b1;
      OPC_FENCE:  dec = CTRL_NOP;
      default:    bad = 1'b1;
    endcase
  end

  // Compressed-space words are rejected even if the opcode bits look familiar
  assign illegal = bad || (instr[1:0] != 2'b11);
  assign ctrl    = illegal ? CTRL_NOP : dec;
  assign use_rs1 = dec_rs1 && !illegal;
  assign use_rs2 = dec_rs2 && !illegal;

endmodule

// File: rtl/decode_queue.sv
// Fetch-to-execute instruction queue: DEPTH-entry FIFO, registered decode of the head,
// flush, and a halt FSM that freezes issue after a SYSTEM instruction.
module decode_queue
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_W-1:0]        in_pc,
  input  logic [31:0]            in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output control_t               out_ctrl,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [4:0]             out_rd,
  output logic                   out_use_rs1,
  output logic                   out_use_rs2,
  output logic                   out_illegal,
  output logic                   halted,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_RUN, S_HALT} halt_state_t;

  halt_state_t     state, state_d;
  logic [PC_W-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, load;

  control_t   head_ctrl;
  logic [4:0] head_rs1, head_rs2, head_rd;
  logic       head_use_rs1, head_use_rs2, head_illegal;

  assign in_ready = (count < (AW+1)'(DEPTH)) && !flush;
  assign push     = in_valid && in_ready;
  assign load     = (count != '0) && (state == S_RUN) && (!out_valid || out_ready);
  assign halted   = (state == S_HALT);

  decode_core u_decode (
    .instr   (instr_mem[rd_ptr]),
    .ctrl    (head_ctrl),
    .rs1     (head_rs1),
    .rs2     (head_rs2),
    .rd      (head_rd),
    .use_rs1 (head_use_rs1),
    .use_rs2 (head_use_rs2),
    .illegal (head_illegal)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_ctrl    <= CTRL_NOP;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_use_rs1 <= 1'b0;
      out_use_rs2 <= 1'b0;
      out_illegal <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_pc      <= pc_mem[rd_ptr];
      out_ctrl    <= head_ctrl;
      out_rs1     <= head_rs1;
      out_rs2     <= head_rs2;
      out_rd      <= head_rd;
      out_use_rs1 <= head_use_rs1;
      out_use_rs2 <= head_use_rs2;
      out_illegal <= head_illegal;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) state <= S_RUN;
    else              state <= state_d;
  end

  // Only flush or reset leaves HALT
  always_comb begin
    state_d = state;
    case (state)
      S_RUN:  if (load && head_ctrl.system) state_d = S_HALT;
      S_HALT: state_d = S_HALT;
    endcase
  end

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue; expectations for the mul encoding follow RV32M_EN.
module tb_decode_queue;
  import rv32i_pkg::*;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc;
  control_t    out_ctrl;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_use_rs1, out_use_rs2, out_illegal, halted;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    alu_op_t     alu;
    op2_sel_t    op2;
    logic        rw, mw, sys, u1, u2, ill;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  decode_queue #(.DEPTH(4), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_ctrl(out_ctrl), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_use_rs1(out_use_rs1), .out_use_rs2(out_use_rs2),
    .out_illegal(out_illegal), .halted(halted), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_bundle(input logic [31:0] pc, input logic [4:0] rd, rs1, rs2,
                               input alu_op_t alu, input op2_sel_t op2,
                               input logic rw, mw, sys, u1, u2, ill);
    exp_t e;
    e.pc = pc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.alu = alu; e.op2 = op2;
    e.rw = rw; e.mw = mw; e.sys = sys; e.u1 = u1; e.u2 = u2; e.ill = ill;
    sb.push_back(e);
  endtask

  task automatic push_cycle(input logic [31:0] pc, input logic [31:0] instr);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
    tick();
  endtask

  // A handshake happens at the next rising edge when these hold at the falling edge
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_bundle: got pc=%h, want no bundle", out_pc);
      end else begin
        mon_e = sb.pop_front();
        if ({out_pc, out_rd, out_rs1, out_rs2, out_ctrl.alu_op, out_ctrl.op2_sel, out_ctrl.reg_write,
             out_ctrl.mem_write, out_ctrl.system, out_use_rs1, out_use_rs2, out_illegal} !==
            {mon_e.pc, mon_e.rd, mon_e.rs1, mon_e.rs2, mon_e.alu, mon_e.op2, mon_e.rw,
             mon_e.mw, mon_e.sys, mon_e.u1, mon_e.u2, mon_e.ill}) begin
          errors++;
          $display("[TB] FAIL bundle_pc_%h: got pc=%h rd=%0d rs1=%0d rs2=%0d alu=%0d op2=%0d rw=%b mw=%b sys=%b u1=%b u2=%b ill=%b; want pc=%h rd=%0d rs1=%0d rs2=%0d alu=%0d op2=%0d rw=%b mw=%b sys=%b u1=%b u2=%b ill=%b",
                   mon_e.pc, out_pc, out_rd, out_rs1, out_rs2, out_ctrl.alu_op, out_ctrl.op2_sel,
                   out_ctrl.reg_write, out_ctrl.mem_write, out_ctrl.system, out_use_rs1, out_use_rs2,
                   out_illegal, mon_e.pc, mon_e.rd, mon_e.rs1, mon_e.rs2, mon_e.alu, mon_e.op2,
                   mon_e.rw, mon_e.mw, mon_e.sys, mon_e.u1, mon_e.u2, mon_e.ill);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_instr = '0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
    checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %b want 0", halted); end
    checks++; if ({out_pc, out_illegal, out_ctrl.reg_write, out_ctrl.mem_write} !== 35'd0) begin
      errors++; $display("[TB] FAIL reset_outputs: got pc=%h ill=%b rw=%b mw=%b want all 0", out_pc, out_illegal, out_ctrl.reg_write, out_ctrl.mem_write);
    end
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    expect_bundle(32'h100, 5'd1, 5'd0, 5'd5, ALU_ADD, OP2_IMM, 1, 0, 0, 1, 0, 0);
    push_cycle(32'h100, 32'h00500093);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_latency_early: got out_valid=%b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_latency: got out_valid=%b want 1", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0 || sb.size() != 0) begin
      errors++; $display("[TB] FAIL single_consumed: got out_valid=%b pending=%0d want 0 0", out_valid, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept_%0d: got in_ready=%b want 1", i, in_ready); end
      expect_bundle(32'h200 + 32'(4 * i), 5'(i), 5'd0, 5'(i), ALU_ADD, OP2_IMM, 1, 0, 0, 1, 0, 0);
      push_cycle(32'h200 + 32'(4 * i), {7'd0, 5'(i), 5'd0, 3'd0, 5'(i), 7'h13});
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL b2b_full_count: got %0d want 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_full_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_out_valid: got %b want 1", out_valid); end
    tick();
    checks++; if (out_pc !== 32'h204) begin errors++; $display("[TB] FAIL b2b_stall_hold: got pc=%h want 00000204", out_pc); end
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 20) begin tick(); n++; end
    checks++; if (n != 5) begin errors++; $display("[TB] FAIL b2b_drain_cycles: got %0d want 5", n); end
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_empty: got count=%0d out_valid=%b want 0 0", count, out_valid);
    end
  endtask

  task automatic test_illegal();
    int n;
    out_ready = 1'b1;
    expect_bundle(32'h300, 5'd31, 5'd31, 5'd31, ALU_ADD, OP2_IMM, 0, 0, 0, 0, 0, 1);
    expect_bundle(32'h304, 5'd0, 5'd0, 5'd0, ALU_ADD, OP2_IMM, 0, 0, 0, 0, 0, 1);
    expect_bundle(32'h308, 5'd0, 5'd0, 5'd0, ALU_ADD, OP2_IMM, 0, 0, 0, 0, 0, 1);
    expect_bundle(32'h30C, 5'd3, 5'd1, 5'd2, ALU_ADD, OP2_RS2, 1, 0, 0, 1, 1, 0);
    expect_bundle(32'h310, 5'd3, 5'd1, 5'd2, ALU_SUB, OP2_RS2, 1, 0, 0, 1, 1, 0);
    expect_bundle(32'h314, 5'd3, 5'd1, 5'd2, ALU_ADD, OP2_IMM, 0, 0, 0, 0, 0, 1);
    expect_bundle(32'h318, 5'd1, 5'd1, 5'd1, ALU_ADD, OP2_IMM, 0, 0, 0, 0, 0, 1);
    expect_bundle(32'h31C, 5'd1, 5'd1, 5'd0, ALU_ADD, OP2_IMM, 0, 0, 0, 0, 0, 1);
    expect_bundle(32'h320, 5'd4, 5'd1, 5'd2, ALU_ADD, OP2_IMM, 0, 1, 0, 1, 1, 0);
    expect_bundle(32'h324, 5'd0, 5'd0, 5'd0, ALU_ADD, OP2_IMM, 0, 0, 0, 0, 0, 0);
    push_cycle(32'h300, 32'hFFFFFFFF);
    push_cycle(32'h304, 32'h0000207F);
    push_cycle(32'h308, 32'h00000012);
    push_cycle(32'h30C, 32'h002081B3);
    push_cycle(32'h310, 32'h402081B3);
    push_cycle(32'h314, 32'h202081B3);
    push_cycle(32'h318, 32'h40109093);
    push_cycle(32'h31C, 32'h0000B083);
    push_cycle(32'h320, 32'h0020A223);
    push_cycle(32'h324, 32'h0000000F);
    in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin tick(); n++; end
    checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL illegal_drain: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_halt();
    out_ready = 1'b0;
    expect_bundle(32'h400, 5'd0, 5'd0, 5'd0, ALU_ADD, OP2_IMM, 0, 0, 1, 0, 0, 0);
    push_cycle(32'h400, 32'h00000073);
    push_cycle(32'h404, 32'h00500093);
    in_valid = 1'b0;
    checks++; if (halted !== 1'b1 || out_valid !== 1'b1 || out_ctrl.system !== 1'b1) begin
      errors++; $display("[TB] FAIL halt_enter: got halted=%b out_valid=%b system=%b want 1 1 1", halted, out_valid, out_ctrl.system);
    end
    tick();
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || count !== 3'd1 || halted !== 1'b1) begin
      errors++; $display("[TB] FAIL halt_frozen: got out_valid=%b count=%0d halted=%b want 0 1 1", out_valid, count, halted);
    end
    push_cycle(32'h408, 32'h00600113);
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || count !== 3'd2) begin
      errors++; $display("[TB] FAIL halt_accepts: got out_valid=%b count=%0d want 0 2", out_valid, count);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (count !== 3'd0 || halted !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL halt_flush: got count=%0d halted=%b out_valid=%b want 0 0 0", count, halted, out_valid);
    end
    checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL halt_pending: got %0d want 0", sb.size()); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    push_cycle(32'h500, 32'h00100093);
    push_cycle(32'h504, 32'h00200093);
    push_cycle(32'h508, 32'h00300093);
    checks++; if (count !== 3'd2 || out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL flush_fill: got count=%0d out_valid=%b want 2 1", count, out_valid);
    end
    in_valid = 1'b1; in_pc = 32'h50C; in_instr = 32'h00400093; flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_in_ready: got %b want 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_empty: got count=%0d out_valid=%b want 0 0", count, out_valid);
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_reissue: got %b want 0", out_valid); end
    push_cycle(32'h600, 32'h00100093);
    push_cycle(32'h604, 32'h00200093);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0 || out_illegal !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_midstream: got count=%0d out_valid=%b pc=%h ill=%b want 0 0 0 0", count, out_valid, out_pc, out_illegal);
    end
  endtask

  task automatic test_rv32m();
    int n;
    out_ready = 1'b1;
`ifdef RV32M_EN
    expect_bundle(32'h700, 5'd3, 5'd1, 5'd2, ALU_MUL, OP2_RS2, 1, 0, 0, 1, 1, 0);
`else
    expect_bundle(32'h700, 5'd3, 5'd1, 5'd2, ALU_ADD, OP2_IMM, 0, 0, 0, 0, 0, 1);
`endif
    push_cycle(32'h700, 32'h022081B3);
    in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 10) begin tick(); n++; end
    checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL rv32m_drain: got %0d pending want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_illegal();
    test_halt();
    test_flush();
    test_rv32m();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
